// File: rtl/dffre_bist_checker.sv
// Built-in driver/checker for a single dffre cell: directed then LFSR
// vectors, compared against an internal reference flop.
module dffre_bist_checker #(
  parameter int          NUM_RANDOM    = 1000,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          MCW           = 16,
  parameter int          VCW           = 16
) (
  input  logic           clk,
  input  logic           i_Reset_n,
  input  logic           i_Start,
  output logic           o_DutReset_n,
  output logic           o_DutEnable,
  output logic           o_DutD,
  input  logic           i_Q,
  output logic           o_Busy,
  output logic           o_Done,
  output logic           o_Pass,
  output logic [MCW-1:0] o_MismatchCount,
  output logic [VCW-1:0] o_VecCount
);

  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam int TOTAL = 6 + NUM_RANDOM;
  localparam int WCW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(SETTLE_CYCLES - 1);
  localparam logic [VCW-1:0] VLAST = VCW'(TOTAL - 1);

  typedef enum logic [2:0] {
    IDLE, APPLY, WAIT, CHECK, DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]    lfsr;
  logic [15:0]    lfsr_nxt;
  logic [WCW-1:0] wait_cnt;
  logic           model_q;
  logic           is_dir;
  logic           last;
  logic [2:0]     vec;
  logic [MCW-1:0] mm_nxt;

  assign is_dir = o_VecCount < VCW'(6);
  assign last   = o_VecCount == VLAST;
  assign o_Busy = (state == APPLY) || (state == WAIT) ||
                  (state == CHECK);
  assign o_Done = state == DONE;

  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5],
                     lfsr[15:1]};

  // {rst_n, en, d} for the vector about to launch
  always_comb begin
    vec = {1'b1, lfsr[1], lfsr[0]};
    if (is_dir) begin
      case (o_VecCount[2:0])
        3'd0:    vec = 3'b001;
        3'd1:    vec = 3'b101;
        3'd2:    vec = 3'b111;
        3'd3:    vec = 3'b110;
        3'd4:    vec = 3'b111;
        3'd5:    vec = 3'b100;
        default: vec = 3'b001;
      endcase
    end
  end

  always_comb begin
    mm_nxt = o_MismatchCount;
    if ((i_Q != model_q) && (o_MismatchCount != '1))
      mm_nxt = o_MismatchCount + MCW'(1);
  end

  always_ff @(posedge clk or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (i_Start) state_nxt = APPLY;
      APPLY: state_nxt = WAIT;
      WAIT:  if (wait_cnt == WLAST) state_nxt = CHECK;
      CHECK: state_nxt = last ? DONE : APPLY;
      DONE:  if (i_Start) state_nxt = APPLY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_DutReset_n    <= 1'b0;
      o_DutEnable     <= 1'b0;
      o_DutD          <= 1'b0;
      o_Pass          <= 1'b0;
      o_MismatchCount <= '0;
      o_VecCount      <= '0;
      model_q         <= 1'b0;
      lfsr            <= SEED;
      wait_cnt        <= '0;
    end else begin
      model_q <= !o_DutReset_n ? 1'b0 :
                 o_DutEnable   ? o_DutD : model_q;
      case (state)
        IDLE, DONE: begin
          if (i_Start) begin
            o_MismatchCount <= '0;
            o_VecCount      <= '0;
            o_Pass          <= 1'b0;
            lfsr            <= SEED;
          end
        end
        APPLY: begin
          {o_DutReset_n, o_DutEnable, o_DutD} <= vec;
          if (!is_dir) lfsr <= lfsr_nxt;
          wait_cnt <= '0;
        end
        WAIT: wait_cnt <= wait_cnt + WCW'(1);
        CHECK: begin
          o_MismatchCount <= mm_nxt;
          o_VecCount      <= o_VecCount + VCW'(1);
          if (last) o_Pass <= mm_nxt == '0;
        end
        default: ;
      endcase
    end
  end

endmodule
